// File: rtl/core_pkg.sv
// Shared types and constants for the multicycle RV32 control path.
package core_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_HALT     = 4'd11
  } state_e;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b1000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Per-state control word; fetch marks the outputs gated by MemReady.
  typedef struct packed {
    logic       fetch;
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  // Immediate format from opcode; anything not S/B/J uses the I layout.
  function automatic logic [1:0] imm_src(input logic [6:0] op);
    logic [1:0] sel;
    case (op)
      OP_STORE:  sel = IMM_S;
      OP_BRANCH: sel = IMM_B;
      OP_JAL:    sel = IMM_J;
      default:   sel = IMM_I;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory signal bundle.
interface multicycle_controller_if;
  logic [31:0] Instr;
  logic        Zero;
  logic        MemReady;
  logic        PCWrite;
  logic        AdrSrc;
  logic        MemRead;
  logic        MemWrite;
  logic        IRWrite;
  logic [1:0]  ResultSrc;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [3:0]  ALUControl;
  logic [1:0]  ImmSrc;
  logic        RegWrite;
  logic        Illegal;
  logic [3:0]  State;

  modport master (
    input  Instr, Zero, MemReady,
    output PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegWrite, Illegal, State
  );

  modport slave (
    output Instr, Zero, MemReady,
    input  PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegWrite, Illegal, State
  );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU operation decode shared with the single-cycle core.
module alu_decoder
  import core_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       opb5_i,
  output logic [3:0] alu_control_o
);

  // ALUOp selects fixed add/sub or funct-driven decode.
  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_ADD: alu_control_o = ALU_ADD;
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          3'b000:  alu_control_o = (opb5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control_o = ALU_SLT;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32 control FSM: sequences ALU, unified memory port and
// register file; registered Moore control word plus MemReady gating in FETCH.
module multicycle_controller
  import core_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst_n,
  multicycle_controller_if.master        bus
);

  state_e     state_q, state_d;
  ctrl_t      ctrl_q;
  logic       illegal_q;
  logic [6:0] opcode;
  logic [3:0] alu_control;
  logic       unused_instr;

  assign opcode       = bus.Instr[6:0];
  assign unused_instr = ^{bus.Instr[31], bus.Instr[29:15], bus.Instr[11:7]};

  // Control word for each state; the word for the next state is registered
  // so outputs come straight from flops.
  function automatic ctrl_t ctrl_of(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.fetch      = 1'b1;
        c.pc_update  = 1'b1;
        c.mem_read   = 1'b1;
        c.alu_src_a  = SRCA_PC;
        c.alu_src_b  = SRCB_FOUR;
        c.alu_op     = ALUOP_ADD;
        c.result_src = RES_ALURESULT;
      end
      S_DECODE: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        c.alu_src_a = SRCA_RD1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      S_MEMREAD: begin
        c.result_src = RES_ALUOUT;
        c.adr_src    = 1'b1;
        c.mem_read   = 1'b1;
      end
      S_MEMWB: begin
        c.result_src = RES_DATA;
        c.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        c.result_src = RES_ALUOUT;
        c.adr_src    = 1'b1;
        c.mem_write  = 1'b1;
      end
      S_EXECR: begin
        c.alu_src_a = SRCA_RD1;
        c.alu_src_b = SRCB_RD2;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        c.alu_src_a = SRCA_RD1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        c.result_src = RES_ALUOUT;
        c.reg_write  = 1'b1;
      end
      S_JAL: begin
        c.alu_src_a  = SRCA_OLDPC;
        c.alu_src_b  = SRCB_FOUR;
        c.alu_op     = ALUOP_ADD;
        c.result_src = RES_ALUOUT;
        c.pc_update  = 1'b1;
      end
      S_BEQ: begin
        c.alu_src_a  = SRCA_RD1;
        c.alu_src_b  = SRCB_RD2;
        c.alu_op     = ALUOP_SUB;
        c.result_src = RES_ALUOUT;
        c.branch     = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next-state selection; MemReady only matters in the memory wait states.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (bus.MemReady) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_HALT;
        endcase
      end
      S_MEMADR:   state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (bus.MemReady) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (bus.MemReady) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_BEQ:      state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_HALT;
    endcase
  end

  // State, registered control word and sticky illegal flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      ctrl_q    <= ctrl_of(S_FETCH);
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_of(state_d);
      illegal_q <= illegal_q | (state_d == S_HALT);
    end
  end

  alu_decoder u_alu_decoder (
    .alu_op_i      (ctrl_q.alu_op),
    .funct3_i      (bus.Instr[14:12]),
    .funct7b5_i    (bus.Instr[30]),
    .opb5_i        (bus.Instr[5]),
    .alu_control_o (alu_control)
  );

  // PC update in FETCH waits for the instruction word; JAL's does not.
  assign bus.PCWrite    = (ctrl_q.pc_update & (~ctrl_q.fetch | bus.MemReady))
                        | (ctrl_q.branch & bus.Zero);
  assign bus.IRWrite    = ctrl_q.fetch & bus.MemReady;
  assign bus.AdrSrc     = ctrl_q.adr_src;
  assign bus.MemRead    = ctrl_q.mem_read;
  assign bus.MemWrite   = ctrl_q.mem_write;
  assign bus.RegWrite   = ctrl_q.reg_write;
  assign bus.ResultSrc  = ctrl_q.result_src;
  assign bus.ALUSrcA    = ctrl_q.alu_src_a;
  assign bus.ALUSrcB    = ctrl_q.alu_src_b;
  assign bus.ALUControl = alu_control;
  assign bus.ImmSrc     = imm_src(opcode);
  assign bus.Illegal    = illegal_q;
  assign bus.State      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed, table-driven bench for multicycle_controller.
module tb_multicycle_controller;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, adr, mrd, mwr, irw;
    logic [1:0] res, a, b;
    logic [3:0] alu;
    logic [1:0] imm;
    logic       rw, ill;
  } out_t;

  typedef struct {
    logic [31:0] instr;
    logic        zero;
    logic        mr;
    out_t        exp;
  } vec_t;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_AND  = 32'h0020F1B3;
  localparam logic [31:0] I_LW   = 32'h0040A283;
  localparam logic [31:0] I_SW   = 32'h0050A223;
  localparam logic [31:0] I_SLTI = 32'h0030A293;
  localparam logic [31:0] I_ORI  = 32'h0030E293;
  localparam logic [31:0] I_ADDI = 32'h40008293;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_JAL  = 32'h010000EF;
  localparam logic [31:0] I_BAD  = 32'h0000007F;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  vec_t vecs[$];

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t sample();
    out_t o;
    o = {bus.State, bus.PCWrite, bus.AdrSrc, bus.MemRead, bus.MemWrite,
         bus.IRWrite, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB,
         bus.ALUControl, bus.ImmSrc, bus.RegWrite, bus.Illegal};
    return o;
  endfunction

  // flags = {PCWrite, AdrSrc, MemRead, MemWrite, IRWrite}
  function automatic void add(logic [31:0] instr, logic z, logic mr,
                              logic [3:0] st, logic [4:0] flags,
                              logic [1:0] res, logic [1:0] a, logic [1:0] b,
                              logic [3:0] alu, logic [1:0] imm,
                              logic rw, logic ill);
    vec_t v;
    v.instr = instr;
    v.zero  = z;
    v.mr    = mr;
    v.exp   = {st, flags, res, a, b, alu, imm, rw, ill};
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    out_t act;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.Instr = I_ADD;
    bus.Zero = 1'b0;
    bus.MemReady = 1'b0;

    // add / sub / and
    add(I_ADD, 0, 1, 4'd0, 5'b10101, 2'd2, 2'd0, 2'd2, 4'h0, 2'd0, 0, 0);
    add(I_ADD, 0, 0, 4'd1, 5'b00000, 2'd0, 2'd1, 2'd1, 4'h0, 2'd0, 0, 0);
    add(I_ADD, 0, 1, 4'd6, 5'b00000, 2'd0, 2'd2, 2'd0, 4'h0, 2'd0, 0, 0);
    add(I_ADD, 0, 0, 4'd7, 5'b00000, 2'd0, 2'd0, 2'd0, 4'h0, 2'd0, 1, 0);
    add(I_SUB, 0, 1, 4'd0, 5'b10101, 2'd2, 2'd0, 2'd2, 4'h0, 2'd0, 0, 0);
    add(I_SUB, 0, 1, 4'd1, 5'b00000, 2'd0, 2'd1, 2'd1, 4'h0, 2'd0, 0, 0);
    add(I_SUB, 0, 1, 4'd6, 5'b00000, 2'd0, 2'd2, 2'd0, 4'h1, 2'd0, 0, 0);
    add(I_SUB, 0, 1, 4'd7, 5'b00000, 2'd0, 2'd0, 2'd0, 4'h0, 2'd0, 1, 0);
    add(I_AND, 0, 1, 4'd0, 5'b10101, 2'd2, 2'd0, 2'd2, 4'h0, 2'd0, 0, 0);
    add(I_AND, 0, 1, 4'd1, 5'b00000, 2'd0, 2'd1, 2'd1, 4'h0, 2'd0, 0, 0);
    add(I_AND, 0, 1, 4'd6, 5'b00000, 2'd0, 2'd2, 2'd0, 4'h2, 2'd0, 0, 0);
    add(I_AND, 0, 1, 4'd7, 5'b00000, 2'd0, 2'd0, 2'd0, 4'h0, 2'd0, 1, 0);
    // lw with two wait cycles in MEMREAD: 7 cycles
    add(I_LW,  0, 1, 4'd0, 5'b10101, 2'd2, 2'd0, 2'd2, 4'h0, 2'd0, 0, 0);
    add(I_LW,  0, 1, 4'd1, 5'b00000, 2'd0, 2'd1, 2'd1, 4'h0, 2'd0, 0, 0);
    add(I_LW,  0, 1, 4'd2, 5'b00000, 2'd0, 2'd2, 2'd1, 4'h0, 2'd0, 0, 0);
    add(I_LW,  0, 0, 4'd3, 5'b01100, 2'd0, 2'd0, 2'd0, 4'h0, 2'd0, 0, 0);
    add(I_LW,  0, 0, 4'd3, 5'b01100, 2'd0, 2'd0, 2'd0, 4'h0, 2'd0, 0, 0);
    add(I_LW,  0, 1, 4'd3, 5'b01100, 2'd0, 2'd0, 2'd0, 4'h0, 2'd0, 0, 0);
    add(I_LW,  0, 1, 4'd4, 5'b00000, 2'd1, 2'd0, 2'd0, 4'h0, 2'd0, 1, 0);
    // sw with one FETCH wait and one MEMWRITE wait
    add(I_SW,  0, 0, 4'd0, 5'b00100, 2'd2, 2'd0, 2'd2, 4'h0, 2'd1, 0, 0);
    add(I_SW,  0, 1, 4'd0, 5'b10101, 2'd2, 2'd0, 2'd2, 4'h0, 2'd1, 0, 0);
    add(I_SW,  0, 1, 4'd1, 5'b00000, 2'd0, 2'd1, 2'd1, 4'h0, 2'd1, 0, 0);
    add(I_SW,  0, 1, 4'd2, 5'b00000, 2'd0, 2'd2, 2'd1, 4'h0, 2'd1, 0, 0);
    add(I_SW,  0, 0, 4'd5, 5'b01010, 2'd0, 2'd0, 2'd0, 4'h0, 2'd1, 0, 0);
    add(I_SW,  0, 1, 4'd5, 5'b01010, 2'd0, 2'd0, 2'd0, 4'h0, 2'd1, 0, 0);
    // I-type: slti, ori, addi with imm bit 30 set (still ADD)
    add(I_SLTI, 0, 1, 4'd0, 5'b10101, 2'd2, 2'd0, 2'd2, 4'h0, 2'd0, 0, 0);
    add(I_SLTI, 0, 1, 4'd1, 5'b00000, 2'd0, 2'd1, 2'd1, 4'h0, 2'd0, 0, 0);
    add(I_SLTI, 0, 1, 4'd8, 5'b00000, 2'd0, 2'd2, 2'd1, 4'h8, 2'd0, 0, 0);
    add(I_SLTI, 0, 1, 4'd7, 5'b00000, 2'd0, 2'd0, 2'd0, 4'h0, 2'd0, 1, 0);
    add(I_ORI,  0, 1, 4'd0, 5'b10101, 2'd2, 2'd0, 2'd2, 4'h0, 2'd0, 0, 0);
    add(I_ORI,  0, 1, 4'd1, 5'b00000, 2'd0, 2'd1, 2'd1, 4'h0, 2'd0, 0, 0);
    add(I_ORI,  0, 1, 4'd8, 5'b00000, 2'd0, 2'd2, 2'd1, 4'h3, 2'd0, 0, 0);
    add(I_ORI,  0, 1, 4'd7, 5'b00000, 2'd0, 2'd0, 2'd0, 4'h0, 2'd0, 1, 0);
    add(I_ADDI, 0, 1, 4'd0, 5'b10101, 2'd2, 2'd0, 2'd2, 4'h0, 2'd0, 0, 0);
    add(I_ADDI, 0, 1, 4'd1, 5'b00000, 2'd0, 2'd1, 2'd1, 4'h0, 2'd0, 0, 0);
    add(I_ADDI, 0, 1, 4'd8, 5'b00000, 2'd0, 2'd2, 2'd1, 4'h0, 2'd0, 0, 0);
    add(I_ADDI, 0, 1, 4'd7, 5'b00000, 2'd0, 2'd0, 2'd0, 4'h0, 2'd0, 1, 0);
    // beq taken, then not taken; Zero outside BEQ must not write PC
    add(I_BEQ, 1, 1, 4'd0, 5'b10101, 2'd2, 2'd0, 2'd2, 4'h0, 2'd2, 0, 0);
    add(I_BEQ, 1, 1, 4'd1, 5'b00000, 2'd0, 2'd1, 2'd1, 4'h0, 2'd2, 0, 0);
    add(I_BEQ, 1, 1, 4'd10, 5'b10000, 2'd0, 2'd2, 2'd0, 4'h1, 2'd2, 0, 0);
    add(I_BEQ, 0, 1, 4'd0, 5'b10101, 2'd2, 2'd0, 2'd2, 4'h0, 2'd2, 0, 0);
    add(I_BEQ, 0, 1, 4'd1, 5'b00000, 2'd0, 2'd1, 2'd1, 4'h0, 2'd2, 0, 0);
    add(I_BEQ, 0, 1, 4'd10, 5'b00000, 2'd0, 2'd2, 2'd0, 4'h1, 2'd2, 0, 0);
    // jal
    add(I_JAL, 0, 1, 4'd0, 5'b10101, 2'd2, 2'd0, 2'd2, 4'h0, 2'd3, 0, 0);
    add(I_JAL, 0, 1, 4'd1, 5'b00000, 2'd0, 2'd1, 2'd1, 4'h0, 2'd3, 0, 0);
    add(I_JAL, 0, 1, 4'd9, 5'b10000, 2'd0, 2'd1, 2'd2, 4'h0, 2'd3, 0, 0);
    add(I_JAL, 0, 1, 4'd7, 5'b00000, 2'd0, 2'd0, 2'd0, 4'h0, 2'd3, 1, 0);

    // Reset state: FETCH outputs, no enables while MemReady=0
    tick();
    tick();
    act = sample();
    check("reset_state", 32'(act),
          32'({4'd0, 5'b00100, 2'd2, 2'd0, 2'd2, 4'h0, 2'd0, 1'b0, 1'b0}));
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      bus.Instr    = vecs[i].instr;
      bus.Zero     = vecs[i].zero;
      bus.MemReady = vecs[i].mr;
      #1;
      act = sample();
      check($sformatf("vec%0d_state%0d", i, vecs[i].exp.st), 32'(act), 32'(vecs[i].exp));
      tick();
    end

    // Illegal opcode: DECODE -> HALT, then 20 idle cycles until reset
    bus.Instr    = I_BAD;
    bus.MemReady = 1'b1;
    bus.Zero     = 1'b1;
    check("bad_fetch_state", 32'(bus.State), 32'd0);
    tick();
    check("bad_decode_state", 32'(bus.State), 32'd1);
    tick();
    for (int c = 0; c < 20; c++) begin
      check($sformatf("halt%0d", c),
            32'({bus.State, bus.Illegal, bus.PCWrite, bus.IRWrite, bus.MemRead,
                 bus.MemWrite, bus.RegWrite}),
            32'({4'd11, 1'b1, 5'b00000}));
      tick();
    end
    rst_n = 1'b0;
    #1;
    check("halt_reset", 32'({bus.State, bus.Illegal}), 32'({4'd0, 1'b0}));
    tick();

    // Reset while waiting in MEMWRITE
    bus.Instr    = I_SW;
    bus.Zero     = 1'b0;
    bus.MemReady = 1'b1;
    rst_n        = 1'b1;
    tick();
    tick();
    tick();
    bus.MemReady = 1'b0;
    #1;
    check("memwrite_wait", 32'({bus.State, bus.MemWrite}), 32'({4'd5, 1'b1}));
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_in_memwrite",
          32'({bus.State, bus.MemWrite, bus.RegWrite, bus.PCWrite, bus.MemRead}),
          32'({4'd0, 3'b000, 1'b1}));
    tick();
    rst_n = 1'b1;
    tick();
    check("after_release", 32'({bus.State, bus.MemRead, bus.IRWrite, bus.AdrSrc}),
          32'({4'd0, 1'b1, 1'b0, 1'b0}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
